// File: rtl/dnn_uart_tx.sv
// Byte-serial UART transmitter for the accelerator result path.
// Frames a latched byte as start/data/optional parity/stop bits; all outputs registered.
module dnn_uart_tx #(
   parameter int BITWIDTH     = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [BITWIDTH-1:0] dataIn,
   input  logic                doTransmit,
   output logic                isBusy,
   output logic                txd,
   output logic                txDone,
   output logic                overrun
);

   localparam int CW = $clog2(BITWIDTH + STOP_BITS + 1);
   localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(BITWIDTH - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state;
   logic [15:0]         baud_cnt;
   logic [CW-1:0]       bit_cnt;
   logic [BITWIDTH-1:0] shift_reg;
   logic [BITWIDTH-1:0] shift_next;
   logic                parity_bit;
   logic                baud_wrap;

   assign baud_wrap  = (baud_cnt == BAUD_LAST);
   assign shift_next = shift_reg >> 1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         txd        <= 1'b1;
         isBusy     <= 1'b0;
         txDone     <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         txDone <= 1'b0;
         // A strobe while a frame is in flight is dropped but remembered.
         if (doTransmit && state != IDLE)
            overrun <= 1'b1;
         if (state != IDLE)
            baud_cnt <= baud_wrap ? '0 : baud_cnt + 16'd1;

         case (state)
            IDLE: begin
               if (doTransmit) begin
                  shift_reg  <= dataIn;
                  parity_bit <= (^dataIn) ^ PAR_ODD;
                  baud_cnt   <= '0;
                  bit_cnt    <= '0;
                  state      <= START;
                  txd        <= 1'b0;
                  isBusy     <= 1'b1;
               end else begin
                  txd    <= 1'b1;
                  isBusy <= 1'b0;
               end
            end
            START: begin
               if (baud_wrap) begin
                  state <= DATA;
                  txd   <= shift_reg[0];
               end
            end
            DATA: begin
               if (baud_wrap) begin
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        txd   <= parity_bit;
                     end else begin
                        state <= STOP;
                        txd   <= 1'b1;
                     end
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     shift_reg <= shift_next;
                     txd       <= shift_next[0];
                  end
               end
            end
            PARITY: begin
               if (baud_wrap) begin
                  state <= STOP;
                  txd   <= 1'b1;
               end
            end
            STOP: begin
               if (baud_wrap) begin
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     state   <= IDLE;
                     isBusy  <= 1'b0;
                     txDone  <= 1'b1;
                     txd     <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
               isBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule
